sample_capture: RTL and testbench
=================================

SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter WIDTH, default 24, sample width in bits (two's complement).
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-003 Port clk  input  1  system clock; all logic on posedge clk.
REQ-004 Port rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 Port sample_in  input  WIDTH  signed filtered sample from the filter output.
REQ-006 Port sample_stb  input  1  one-cycle pulse marking sample_in valid.
REQ-007 Port start  input  1  one-cycle pulse that arms a capture run.
REQ-008 Port capture_len  input  16  samples per run; 0 means unbounded; latched on start.
REQ-009 Port out_data  output  WIDTH  FIFO head sample.
REQ-010 Port out_valid  output  1  FIFO non-empty.
REQ-011 Port out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-012 Port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 Port busy  output  1  high in state RUN.
REQ-014 Port overflow  output  1  sticky, set when a strobed sample is dropped.
REQ-015 Port drop_cnt  output  8  count of dropped samples, saturating at 255.

Function
REQ-016 States IDLE, RUN, DONE; reset state IDLE.
REQ-017 Transitions: IDLE->RUN on start. RUN->DONE when the captured count reaches the latched capture_len, if it is nonzero. DONE->IDLE on the cycle after entry. start in RUN restarts the count and holds RUN.
REQ-018 Strobes are written to the FIFO only in RUN; in IDLE or DONE they are ignored and not counted.
REQ-019 Write on posedge with sample_stb high in RUN and FIFO not full; out_valid rises the following cycle (1-cycle latency).
REQ-020 FIFO is first-word-fall-through; a pop occurs on posedge with out_valid and out_ready both high.
REQ-021 Strobe while full with no pop: sample dropped, overflow set, drop_cnt incremented (saturating); the dropped sample still counts toward capture_len.
REQ-022 Strobe while full with a simultaneous pop: write accepted, no drop, level unchanged.
REQ-023 Simultaneous push and pop when not full or empty: level unchanged, order preserved.
REQ-024 out_ready while empty: no effect; level never underflows.
REQ-025 Read and write pointers wrap modulo DEPTH with no gap or duplication.
REQ-026 overflow and drop_cnt clear only on reset or start.
REQ-027 out_data holds its value while out_valid is high and out_ready is low.

Reset
REQ-028 With rst_n low at posedge: state IDLE, FIFO empty, level 0, out_valid 0, out_data 0, busy 0, overflow 0, drop_cnt 0, captured count 0.
REQ-029 Reset mid-run discards all FIFO contents; no partial-sample output follows.

Configuration
REQ-030 With macro SAMPLE_CAPTURE_PEAK_EN defined:
- add output peak_max (WIDTH, signed) and output peak_min (WIDTH, signed);
- both track the maximum and minimum of accepted samples in the current run;
- on start, or on the first sample of a run, both load that sample;
- reset value of both is 0.
REQ-031 Without SAMPLE_CAPTURE_PEAK_EN, the ports and tracking logic are absent and all other behaviour is identical.

Structure
REQ-032 Package sample_capture_pkg holds the WIDTH and DEPTH defaults, the state enum type, and the drop_cnt width constant.
REQ-033 Storage and pointers live in the sub-module sc_fifo. The FSM, counters and peak logic stay in sample_capture.

Verification
REQ-034 start, capture_len=4, five strobes of 10, -20, 30, -40, 50 with out_ready=0 -> FIFO holds 10, -20, 30, -40; the fifth strobe is ignored; busy falls; DONE lasts one cycle.
REQ-035 capture_len=0 with 17 strobes and out_ready=0 -> level=16, overflow=1, drop_cnt=1, and the head is still the first sample.
REQ-036 Full FIFO, strobe and out_ready on the same cycle -> level stays 16, drop_cnt unchanged, and the new sample appears last.
REQ-037 Strobe of 0x7FFFFF then 0x800000 (-8388608) -> both read back unchanged in order; with PEAK_EN, peak_max=8388607 and peak_min=-8388608.
REQ-038 rst_n low for 1 cycle mid-run with level=5 -> next cycle level=0, out_valid=0, state IDLE, drop_cnt=0.
REQ-039 300 strobes dropped while full -> drop_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/sample_capture_pkg.sv
// sample_capture_pkg: shared defaults, state encoding and counter widths for sample_capture.
package sample_capture_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_DEPTH = 16;
    localparam int DROP_W    = 8;
    localparam int LEN_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sc_fifo.sv
// sc_fifo: first-word-fall-through sample FIFO; pointers carry one extra wrap bit so full and empty differ.
module sc_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LV_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_pop;
    logic             w_push;

    assign o_level = r_wp - r_rp;
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (o_level == LV_FULL);
    assign w_pop   = i_pop & ~o_empty;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_ONE;
            if (w_pop)  r_rp <= r_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/sample_capture.sv
// sample_capture: armed capture of strobed samples into a FWFT FIFO with drop accounting.
// Optional SAMPLE_CAPTURE_PEAK_EN adds per-run peak_max/peak_min tracking.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [WIDTH-1:0]  sample_in,
    input  logic                     sample_stb,
    input  logic                     start,
    input  logic [LEN_W-1:0]         capture_len,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
`ifdef SAMPLE_CAPTURE_PEAK_EN
    ,
    output logic signed [WIDTH-1:0]  peak_max,
    output logic signed [WIDTH-1:0]  peak_min
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovf;
    logic [DROP_W-1:0]  r_drop;
    logic               w_run;
    logic               w_start;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_hit;
    logic               w_full;
    logic               w_empty;

    sc_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (sample_in),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign w_run     = (r_state == RUN);
    assign w_start   = start & (r_state != DONE);
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = w_run & sample_stb & (~w_full | w_pop);
    assign w_drop    = w_run & sample_stb & w_full & ~w_pop;
    // dropped strobes still count toward the run length
    assign w_hit     = w_run & sample_stb & (r_len != '0) & (r_cnt + LEN_W'(1) == r_len);
    assign busy      = w_run;
    assign overflow  = r_ovf;
    assign drop_cnt  = r_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = (w_hit && !start) ? DONE : RUN;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_start) begin
            r_cnt  <= '0;
            r_len  <= capture_len;
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else begin
            if (w_run && sample_stb) r_cnt <= r_cnt + LEN_W'(1);
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

`ifdef SAMPLE_CAPTURE_PEAK_EN
    logic                     r_first;
    logic signed [WIDTH-1:0]  r_pmax;
    logic signed [WIDTH-1:0]  r_pmin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first <= 1'b1;
            r_pmax  <= '0;
            r_pmin  <= '0;
        end else if (w_push && (r_first || w_start)) begin
            r_first <= 1'b0;
            r_pmax  <= sample_in;
            r_pmin  <= sample_in;
        end else if (w_start) begin
            r_first <= 1'b1;
        end else if (w_push) begin
            if (sample_in > r_pmax) r_pmax <= sample_in;
            if (sample_in < r_pmin) r_pmin <= sample_in;
        end
    end

    assign peak_max = r_pmax;
    assign peak_min = r_pmin;
`endif

endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: directed stimulus, queue-based reference model checked every cycle, plus literal checks.
module tb_sample_capture;

    localparam int WIDTH = 24;
    localparam int DEPTH = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic signed [WIDTH-1:0] sample_in;
    logic                    sample_stb;
    logic                    start;
    logic [15:0]             capture_len;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [4:0]              level;
    logic                    busy;
    logic                    overflow;
    logic [7:0]              drop_cnt;
`ifdef SAMPLE_CAPTURE_PEAK_EN
    logic signed [WIDTH-1:0] peak_max;
    logic signed [WIDTH-1:0] peak_min;
`endif

    sample_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_stb  (sample_stb),
        .start       (start),
        .capture_len (capture_len),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .busy        (busy),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
`ifdef SAMPLE_CAPTURE_PEAK_EN
        ,
        .peak_max    (peak_max),
        .peak_min    (peak_min)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] u24(input int x);
        logic [23:0] t;
        t = 24'(x);
        return {40'd0, t};
    endfunction

    // reference model: phase 0 idle, 1 run, 2 done
    logic [WIDTH-1:0] q[$];
    int mphase = 0;
    int mcnt = 0;
    int mlen = 0;
    int mdrop = 0;
    bit movf = 0;
    bit mvalid = 0;

    always @(posedge clk) begin
        bit pop, run, st, dropped;
        if (!rst_n) begin
            q.delete();
            mphase = 0;
            mcnt = 0;
            mlen = 0;
            movf = 0;
            mdrop = 0;
        end else begin
            run = (mphase == 1);
            pop = (q.size() != 0) && out_ready;
            st = start && (mphase != 2);
            dropped = 0;
            if (pop) void'(q.pop_front());
            if (run && sample_stb) begin
                if (q.size() < DEPTH) q.push_back(sample_in);
                else dropped = 1;
            end
            if (mphase == 2) mphase = 0;
            else if (st) begin
                mphase = 1;
                mcnt = 0;
                mlen = int'(capture_len);
                movf = 0;
                mdrop = 0;
            end else if (run) begin
                if (dropped) begin
                    movf = 1;
                    if (mdrop < 255) mdrop++;
                end
                if (sample_stb) begin
                    mcnt++;
                    if (mlen != 0 && mcnt == mlen) mphase = 2;
                end
            end
        end
        mvalid = 1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("level", 64'(level), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
            chk("busy", 64'(busy), 64'(mphase == 1));
            chk("overflow", 64'(overflow), 64'(movf));
            chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
        end
    end

    task automatic cyc(input bit stb, input int d, input bit st, input bit rdy);
        sample_stb = stb;
        sample_in = 24'(d);
        start = st;
        out_ready = rdy;
        @(posedge clk);
        #1;
        sample_stb = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    int a_vals[5] = '{10, -20, 30, -40, 50};

    initial begin
        rst_n = 1'b0;
        sample_stb = 1'b0;
        sample_in = '0;
        start = 1'b0;
        capture_len = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;

        // bounded run of four, fifth strobe lands after the run ends
        capture_len = 16'd4;
        cyc(0, 0, 1, 0);
        chk("A_busy_on", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, a_vals[i], 0, 0);
            if (i == 3) chk("A_busy_off", 64'(busy), 64'd0);
        end
        chk("A_level", 64'(level), 64'd4);
        chk("A_busy_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("A_data", 64'(out_data), u24(a_vals[i]));
            cyc(0, 0, 0, 1);
        end
        chk("A_empty", 64'(out_valid), 64'd0);

        // unbounded run overfilled by one
        capture_len = 16'd0;
        cyc(0, 0, 1, 0);
        for (int i = 1; i <= 17; i++) cyc(1, i, 0, 0);
        chk("B_level", 64'(level), 64'd16);
        chk("B_ovf", 64'(overflow), 64'd1);
        chk("B_drop", 64'(drop_cnt), 64'd1);
        chk("B_head", 64'(out_data), 64'd1);

        // full FIFO with simultaneous push and pop
        cyc(1, 100, 0, 1);
        chk("C_level", 64'(level), 64'd16);
        chk("C_drop", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 16; i++) begin
            chk("C_order", 64'(out_data), u24(i < 15 ? i + 2 : 100));
            cyc(0, 0, 0, 1);
        end
        cyc(0, 0, 0, 1);
        chk("C_underflow", 64'(level), 64'd0);
        chk("C_novalid", 64'(out_valid), 64'd0);

        // extreme two's complement values
        cyc(1, 'h7FFFFF, 0, 0);
        cyc(1, 'h800000, 0, 0);
`ifdef SAMPLE_CAPTURE_PEAK_EN
        chk("D_pmax", {40'd0, peak_max}, u24(8388607));
        chk("D_pmin", {40'd0, peak_min}, u24(-8388608));
`endif
        chk("D_max", 64'(out_data), 64'h7FFFFF);
        cyc(0, 0, 0, 1);
        chk("D_min", 64'(out_data), 64'h800000);
        cyc(0, 0, 0, 1);

        // restart in RUN clears drop state, then saturate drop counter
        cyc(0, 0, 1, 0);
        chk("E_drop_clr", 64'(drop_cnt), 64'd0);
        chk("E_ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 316; i++) cyc(1, i, 0, 0);
        chk("E_drop_sat", 64'(drop_cnt), 64'd255);
        chk("E_ovf", 64'(overflow), 64'd1);
        chk("E_level", 64'(level), 64'd16);
        for (int i = 0; i < 11; i++) cyc(0, 0, 0, 1);
        chk("E_level5", 64'(level), 64'd5);
        chk("E_busy", 64'(busy), 64'd1);

        // reset mid-run
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        chk("R_level", 64'(level), 64'd0);
        chk("R_valid", 64'(out_valid), 64'd0);
        chk("R_busy", 64'(busy), 64'd0);
        chk("R_drop", 64'(drop_cnt), 64'd0);
        chk("R_ovf", 64'(overflow), 64'd0);
        cyc(1, 77, 0, 0);
        chk("R_idle_ignore", 64'(level), 64'd0);

        // head holds while not ready
        capture_len = 16'd2;
        cyc(0, 0, 1, 0);
        cyc(1, 5, 0, 0);
        cyc(1, 6, 0, 0);
        chk("F_busy_off", 64'(busy), 64'd0);
        cyc(0, 0, 0, 0);
        chk("F_hold1", 64'(out_data), 64'd5);
        cyc(0, 0, 0, 0);
        chk("F_hold2", 64'(out_data), 64'd5);
        cyc(0, 0, 0, 1);
        chk("F_next", 64'(out_data), 64'd6);
        cyc(0, 0, 0, 1);
        chk("F_level", 64'(level), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
